ls_exec_unit: RTL and testbench

//  Load/store execution unit: the responder to the LS buffer's in-order request port.
//  - Accepts one memory op at a time from the LS buffer and runs it through the memory controller.
//  - Size-extends load data and broadcasts load results on the LS-unit CDB.
//  - Drives the busy flag the LS buffer checks before issuing.

---
 rtl/ls_exec_unit.sv | 148 ++++++++++++++
 tb/tb_ls_exec_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ls_exec_unit.sv
// Load/store execution unit: takes one LS-buffer request at a time, runs it through the memory
// controller and broadcasts size-extended load results on the LS-unit CDB.
module ls_exec_unit #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OP_W     = 6,
  parameter int unsigned ROB_ID_W = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rdy,
  input  logic                i_enable_signal_from_lsb,
  input  logic [OP_W-1:0]     i_openum_from_lsb,
  input  logic [ADDR_W-1:0]   i_mem_address_from_lsb,
  input  logic [DATA_W-1:0]   i_stored_data_from_lsb,
  input  logic [ROB_ID_W-1:0] i_rob_id_from_lsb,
  output logic                o_busy_signal_to_lsb,
  output logic                o_enable_signal_to_memctrl,
  output logic                o_rw_flag_to_memctrl,
  output logic [ADDR_W-1:0]   o_address_to_memctrl,
  output logic [1:0]          o_size_to_memctrl,
  output logic [DATA_W-1:0]   o_data_to_memctrl,
  input  logic                i_done_signal_from_memctrl,
  input  logic [DATA_W-1:0]   i_data_from_memctrl,
  output logic                o_valid_signal_to_cdb,
  output logic [ROB_ID_W-1:0] o_rob_id_to_cdb,
  output logic [DATA_W-1:0]   o_result_to_cdb,
  input  logic                i_misbranch_flag
);

  // Opcode values follow the shared openum numbering: loads are contiguous and end at LHU.
  localparam logic [OP_W-1:0] OpLb  = OP_W'(11);
  localparam logic [OP_W-1:0] OpLh  = OP_W'(12);
  localparam logic [OP_W-1:0] OpLw  = OP_W'(13);
  localparam logic [OP_W-1:0] OpLbu = OP_W'(14);
  localparam logic [OP_W-1:0] OpLhu = OP_W'(15);
  localparam logic [OP_W-1:0] OpSb  = OP_W'(16);
  localparam logic [OP_W-1:0] OpSh  = OP_W'(17);
  localparam logic [OP_W-1:0] OpSw  = OP_W'(18);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e              r_state;
  logic [OP_W-1:0]     r_op;
  logic                r_is_load;
  logic                r_drop;
  logic                r_mem_en;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cdb_valid;
  logic [ROB_ID_W-1:0] r_cdb_rob;
  logic [ROB_ID_W-1:0] r_rob;
  logic [DATA_W-1:0]   r_cdb_result;

  logic                w_in_is_load;
  logic [1:0]          w_in_size;
  logic [DATA_W-1:0]   w_ext;

  assign w_in_is_load = (i_openum_from_lsb <= OpLhu);

  always_comb begin
    w_in_size = 2'b10;
    case (i_openum_from_lsb)
      OpLb, OpLbu, OpSb: w_in_size = 2'b00;
      OpLh, OpLhu, OpSh: w_in_size = 2'b01;
      OpLw, OpSw:        w_in_size = 2'b10;
      default:           w_in_size = 2'b10;
    endcase
  end

  always_comb begin
    w_ext = i_data_from_memctrl;
    case (r_op)
      OpLb:    w_ext = {{(DATA_W-8){i_data_from_memctrl[7]}}, i_data_from_memctrl[7:0]};
      OpLh:    w_ext = {{(DATA_W-16){i_data_from_memctrl[15]}}, i_data_from_memctrl[15:0]};
      OpLbu:   w_ext = {{(DATA_W-8){1'b0}}, i_data_from_memctrl[7:0]};
      OpLhu:   w_ext = {{(DATA_W-16){1'b0}}, i_data_from_memctrl[15:0]};
      default: w_ext = i_data_from_memctrl;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_op         <= '0;
      r_is_load    <= 1'b0;
      r_drop       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_rw         <= 1'b0;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_wdata      <= '0;
      r_rob        <= '0;
      r_cdb_valid  <= 1'b0;
      r_cdb_rob    <= '0;
      r_cdb_result <= '0;
    end else if (i_rdy) begin
      r_cdb_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // A load arriving with a flush is already squashed; stores are retired and must go out.
          if (i_enable_signal_from_lsb && !(i_misbranch_flag && w_in_is_load)) begin
            r_state   <= StWaitMem;
            r_op      <= i_openum_from_lsb;
            r_is_load <= w_in_is_load;
            r_rob     <= i_rob_id_from_lsb;
            r_drop    <= 1'b0;
            r_mem_en  <= 1'b1;
            r_rw      <= !w_in_is_load;
            r_addr    <= i_mem_address_from_lsb;
            r_size    <= w_in_size;
            r_wdata   <= i_stored_data_from_lsb;
          end
        end
        StWaitMem: begin
          if (i_misbranch_flag && r_is_load) begin
            r_drop <= 1'b1;
          end
          if (i_done_signal_from_memctrl) begin
            r_state  <= StIdle;
            r_mem_en <= 1'b0;
            r_drop   <= 1'b0;
            if (r_is_load && !r_drop && !i_misbranch_flag) begin
              r_cdb_valid  <= 1'b1;
              r_cdb_rob    <= r_rob;
              r_cdb_result <= w_ext;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // The LS buffer registers its enable, so an incoming request must block its next issue now.
  assign o_busy_signal_to_lsb       = (r_state != StIdle) | i_enable_signal_from_lsb;
  assign o_enable_signal_to_memctrl = r_mem_en;
  assign o_rw_flag_to_memctrl       = r_rw;
  assign o_address_to_memctrl       = r_addr;
  assign o_size_to_memctrl          = r_size;
  assign o_data_to_memctrl          = r_wdata;
  assign o_valid_signal_to_cdb      = r_cdb_valid;
  assign o_rob_id_to_cdb            = r_cdb_rob;
  assign o_result_to_cdb            = r_cdb_result;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Self-checking bench for ls_exec_unit: directed scenarios plus randomized ops against a
// behavioural model of size extension and broadcast rules.
module tb_ls_exec_unit;

  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk = 1'b0;
  logic        rst, rdy, en, done, misb;
  logic [5:0]  op_i;
  logic [31:0] addr_i, sd_i, rdat;
  logic [3:0]  rob_i;
  logic        busy, mem_en, rw, cdb_v;
  logic [31:0] maddr, mdata, cdb_res;
  logic [1:0]  msize;
  logic [3:0]  cdb_rob;

  int total = 0;
  int bad   = 0;

  logic [5:0]  p_op;
  logic [31:0] p_addr, p_wd;
  logic [3:0]  p_rob;
  bit          p_drop;

  ls_exec_unit dut (
    .i_clk                      (clk),
    .i_rst                      (rst),
    .i_rdy                      (rdy),
    .i_enable_signal_from_lsb   (en),
    .i_openum_from_lsb          (op_i),
    .i_mem_address_from_lsb     (addr_i),
    .i_stored_data_from_lsb     (sd_i),
    .i_rob_id_from_lsb          (rob_i),
    .o_busy_signal_to_lsb       (busy),
    .o_enable_signal_to_memctrl (mem_en),
    .o_rw_flag_to_memctrl       (rw),
    .o_address_to_memctrl       (maddr),
    .o_size_to_memctrl          (msize),
    .o_data_to_memctrl          (mdata),
    .i_done_signal_from_memctrl (done),
    .i_data_from_memctrl        (rdat),
    .o_valid_signal_to_cdb      (cdb_v),
    .o_rob_id_to_cdb            (cdb_rob),
    .o_result_to_cdb            (cdb_res),
    .i_misbranch_flag           (misb)
  );

  always #5 clk = ~clk;

  function automatic bit is_ld(input logic [5:0] op);
    return (op == LB) || (op == LH) || (op == LW) || (op == LBU) || (op == LHU);
  endfunction

  function automatic logic [1:0] ref_size(input logic [5:0] op);
    if (op == LB || op == LBU || op == SB) return 2'd0;
    if (op == LH || op == LHU || op == SH) return 2'd1;
    return 2'd2;
  endfunction

  // Reference extension written as plain modular arithmetic.
  function automatic logic [31:0] ref_ext(input logic [5:0] op, input logic [31:0] d);
    logic [31:0] b, h, r;
    b = d % 32'd256;
    h = d % 32'd65536;
    r = d;
    if (op == LB)  r = (b >= 32'd128) ? b - 32'd256 : b;
    if (op == LH)  r = (h >= 32'd32768) ? h - 32'd65536 : h;
    if (op == LBU) r = b;
    if (op == LHU) r = h;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] rob, input bit flush);
    bit ld, acc;
    ld  = is_ld(op);
    acc = !(flush && ld);
    tick();
    en = 1'b1; op_i = op; addr_i = a; sd_i = wd; rob_i = rob; misb = flush;
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_comb got=%b exp=1", busy);
    end
    tick();
    en = 1'b0; misb = 1'b0;
    op_i = 6'($urandom); addr_i = $urandom; sd_i = $urandom; rob_i = 4'($urandom);
    @(negedge clk);
    total++;
    if (mem_en !== acc) begin
      bad++; $display("FAIL memen_rise got=%b exp=%b op=%0d", mem_en, acc, op);
    end
    if (acc) begin
      total++;
      if ({rw, maddr, msize, mdata} !== {!ld, a, ref_size(op), wd}) begin
        bad++;
        $display("FAIL mem_req got rw=%b a=%h s=%0d d=%h exp rw=%b a=%h s=%0d d=%h",
                 rw, maddr, msize, mdata, !ld, a, ref_size(op), wd);
      end
    end
    p_op = op; p_addr = a; p_wd = wd; p_rob = rob; p_drop = 1'b0;
  endtask

  // Wait lat cycles, pulse done, optionally flush at wait cycle misb_at and chain a new request at M+1.
  task automatic finish_req(input int lat, input logic [31:0] rd, input int misb_at, input bit chain,
                            input logic [5:0] nop, input logic [31:0] na, input logic [31:0] nwd,
                            input logic [3:0] nrob);
    bit exp_v;
    for (int k = 1; k <= lat; k++) begin
      tick();
      misb = (k == misb_at);
      if (k == misb_at && is_ld(p_op)) p_drop = 1'b1;
      if (k == lat) begin
        done = 1'b1; rdat = rd;
      end
      @(negedge clk);
      total++;
      if (mem_en !== 1'b1 || maddr !== p_addr || busy !== 1'b1 || cdb_v !== 1'b0) begin
        bad++;
        $display("FAIL wait_hold got en=%b a=%h busy=%b v=%b exp en=1 a=%h busy=1 v=0",
                 mem_en, maddr, busy, cdb_v, p_addr);
      end
    end
    tick();
    done = 1'b0; misb = 1'b0; rdat = $urandom;
    if (chain) begin
      en = 1'b1; op_i = nop; addr_i = na; sd_i = nwd; rob_i = nrob;
    end
    exp_v = is_ld(p_op) && !p_drop;
    @(negedge clk);
    total++;
    if (mem_en !== 1'b0 || busy !== chain || cdb_v !== exp_v) begin
      bad++;
      $display("FAIL done_resp got en=%b busy=%b v=%b exp en=0 busy=%b v=%b",
               mem_en, busy, cdb_v, chain, exp_v);
    end
    if (exp_v) begin
      total++;
      if (cdb_rob !== p_rob || cdb_res !== ref_ext(p_op, rd)) begin
        bad++;
        $display("FAIL cdb_data got rob=%0d res=%h exp rob=%0d res=%h",
                 cdb_rob, cdb_res, p_rob, ref_ext(p_op, rd));
      end
    end
    tick();
    en = 1'b0;
    @(negedge clk);
    total++;
    if (cdb_v !== 1'b0) begin
      bad++; $display("FAIL cdb_one_pulse got=%b exp=0", cdb_v);
    end
    if (chain) begin
      total++;
      if ({mem_en, rw, maddr, msize, mdata} !== {1'b1, !is_ld(nop), na, ref_size(nop), nwd}) begin
        bad++;
        $display("FAIL chain_req got en=%b rw=%b a=%h s=%0d d=%h exp a=%h d=%h",
                 mem_en, rw, maddr, msize, mdata, na, nwd);
      end
      p_op = nop; p_addr = na; p_wd = nwd; p_rob = nrob; p_drop = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; en = 1'b0; done = 1'b0; misb = 1'b0;
    op_i = '0; addr_i = '0; sd_i = '0; rob_i = '0; rdat = '0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, mem_en, rw, maddr, msize, mdata, cdb_v, cdb_rob, cdb_res} !== '0) begin
      bad++;
      $display("FAIL reset_state got busy=%b en=%b rw=%b a=%h v=%b res=%h exp all 0",
               busy, mem_en, rw, maddr, cdb_v, cdb_res);
    end
  endtask

  task automatic test_lw();
    issue_req(LW, 32'h100, 32'h0, 4'd5, 1'b0);
    finish_req(3, 32'hDEADBEEF, 0, 1'b0, LW, 0, 0, 0);
  endtask

  task automatic test_extension();
    logic [5:0] ops [5];
    ops = '{LB, LBU, LH, LHU, LW};
    for (int i = 0; i < 5; i++) begin
      issue_req(ops[i], 32'h40 + 32'(i), 32'h0, 4'(i + 1), 1'b0);
      finish_req(2, 32'h00008080, 0, 1'b0, LW, 0, 0, 0);
    end
  endtask

  task automatic test_store();
    issue_req(SW, 32'h200, 32'h12345678, 4'd7, 1'b0);
    finish_req(2, 32'hFFFFFFFF, 0, 1'b0, LW, 0, 0, 0);
    issue_req(SB, 32'h203, 32'hA5A5A5A5, 4'd8, 1'b0);
    finish_req(1, 32'h0, 0, 1'b0, LW, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    issue_req(LH, 32'h300, 32'h0, 4'd3, 1'b0);
    finish_req(2, 32'h0000F00F, 0, 1'b1, SH, 32'h304, 32'hCAFE1234, 4'd4);
    finish_req(1, 32'h0, 0, 1'b1, LBU, 32'h308, 32'h0, 4'd9);
    finish_req(2, 32'h000000FE, 0, 1'b0, LW, 0, 0, 0);
  endtask

  task automatic test_misbranch();
    issue_req(LW, 32'h400, 32'h0, 4'd6, 1'b0);
    finish_req(3, 32'h11112222, 2, 1'b0, LW, 0, 0, 0);
    issue_req(SW, 32'h404, 32'h55667788, 4'd2, 1'b0);
    finish_req(3, 32'h0, 1, 1'b0, LW, 0, 0, 0);
    issue_req(LB, 32'h408, 32'h0, 4'd1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      total++;
      if (mem_en !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL flushed_load got en=%b busy=%b exp 0 0", mem_en, busy);
      end
    end
    issue_req(SH, 32'h40C, 32'h0000BEEF, 4'd11, 1'b1);
    finish_req(2, 32'h0, 0, 1'b0, LW, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    issue_req(LW, 32'h500, 32'h0, 4'd12, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, mem_en, rw, maddr, msize, mdata, cdb_v, cdb_rob, cdb_res} !== '0) begin
      bad++;
      $display("FAIL rst_mid got busy=%b en=%b a=%h v=%b exp all 0", busy, mem_en, maddr, cdb_v);
    end
    issue_req(LBU, 32'h504, 32'h0, 4'd13, 1'b0);
    finish_req(1, 32'h000000C3, 0, 1'b0, LW, 0, 0, 0);
  endtask

  task automatic test_rdy_freeze();
    issue_req(LH, 32'h600, 32'h0, 4'd14, 1'b0);
    tick();
    rdy = 1'b0; done = 1'b1; rdat = 32'h00009ABC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (mem_en !== 1'b1 || busy !== 1'b1 || cdb_v !== 1'b0 || maddr !== 32'h600) begin
        bad++;
        $display("FAIL rdy_freeze got en=%b busy=%b v=%b exp en=1 busy=1 v=0", mem_en, busy, cdb_v);
      end
      tick();
    end
    rdy = 1'b1;
    tick();
    done = 1'b0;
    @(negedge clk);
    total++;
    if (cdb_v !== 1'b1 || cdb_res !== ref_ext(LH, 32'h00009ABC) || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL rdy_resume got v=%b res=%h en=%b exp v=1 res=%h en=0",
               cdb_v, cdb_res, mem_en, ref_ext(LH, 32'h00009ABC));
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    logic [5:0] op;
    int lat, mat;
    bit flush;
    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
    for (int i = 0; i < 40; i++) begin
      op    = ops[$urandom_range(0, 7)];
      lat   = int'($urandom_range(1, 4));
      flush = ($urandom_range(0, 7) == 0);
      mat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      if (mat > lat) mat = lat;
      issue_req(op, $urandom, $urandom, 4'($urandom_range(1, 15)), flush);
      if (!(flush && is_ld(op))) finish_req(lat, $urandom, mat, 1'b0, LW, 0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extension();
    test_store();
    test_back_to_back();
    test_misbranch();
    test_rst_mid();
    test_rdy_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
